// File: rtl/step_dir_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : step_dir_decoder                                             |
// | Description : Receives an EasyDriver step/dir/enable triplet. It filters   |
// |               the inputs, tracks signed position, step period and protocol |
// |               violations, and exposes them via an Avalon-MM slave.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module step_dir_decoder #(
  parameter int POS_WIDTH        = 32,
  parameter int FILTER_CYCLES    = 4,
  parameter int MIN_HIGH_CYCLES  = 50,
  parameter int DIR_SETUP_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  input  logic        dir,
  input  logic        enable,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        step_pulse
);

  localparam int c_FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam int c_HI_W  = $clog2(MIN_HIGH_CYCLES + 1);
  localparam int c_AGE_W = $clog2(DIR_SETUP_CYCLES + 1);
  // Idle levels of {enable, dir, step}: ENABLE is active-low, so it idles high.
  localparam logic [2:0] c_IDLE = 3'b100;
  localparam logic [POS_WIDTH-1:0] c_POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] c_POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic [c_AGE_W-1:0]   c_AGE_SAT = c_AGE_W'(DIR_SETUP_CYCLES);
  localparam logic [c_HI_W-1:0]    c_HI_MIN  = c_HI_W'(MIN_HIGH_CYCLES);

  logic [2:0] w_raw;
  logic [2:0] w_filt;   // [0] step, [1] dir, [2] enable (active-low)

  assign w_raw = {enable, dir, step};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_filter
      logic               r_meta;
      logic               r_sync;
      logic               r_val;
      logic [c_FLT_W-1:0] r_cnt;

      // Synchronize, then accept a new level only after it has persisted long enough.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_meta <= c_IDLE[gi];
          r_sync <= c_IDLE[gi];
          r_val  <= c_IDLE[gi];
          r_cnt  <= '0;
        end else begin
          r_meta <= w_raw[gi];
          r_sync <= r_meta;
          if (r_sync == r_val) begin
            r_cnt <= '0;
          end else if (r_cnt == c_FLT_W'(FILTER_CYCLES)) begin
            r_val <= r_sync;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_FLT_W'(1);
          end
        end
      end

      assign w_filt[gi] = r_val;
    end
  endgenerate

  logic                 r_step_d;
  logic                 r_dir_d;
  logic [c_AGE_W-1:0]   r_dir_age;
  logic [c_HI_W-1:0]    r_hi_cnt;
  logic [31:0]          r_per_cnt;
  logic [31:0]          r_period;
  logic [31:0]          r_total;
  logic [POS_WIDTH-1:0] r_pos;
  logic [3:0]           r_sticky;   // {DIS, OVF, SHORT, SETUP}
  logic [31:0]          w_rd_mux;
  logic [31:0]          w_pos_ext;

  logic w_rise, w_fall, w_dir_chg, w_accept;
  logic w_wr_pos, w_wr_status, w_wr_total;
  logic w_setup_viol, w_short, w_ovf;
  logic [3:0] w_set, w_clr;
  logic w_unused;

  assign w_rise      = w_filt[0] & ~r_step_d;
  assign w_fall      = ~w_filt[0] & r_step_d;
  assign w_dir_chg   = w_filt[1] ^ r_dir_d;
  assign w_accept    = w_rise & ~w_filt[2];

  assign w_wr_pos    = avs_write && (avs_address == 2'd0);
  assign w_wr_status = avs_write && (avs_address == 2'd1);
  assign w_wr_total  = avs_write && (avs_address == 2'd3);

  // A dir change coincident with the rise has not yet cleared the age register.
  assign w_setup_viol = w_rise & (w_dir_chg | (r_dir_age < c_AGE_SAT));
  assign w_short      = w_fall & (r_hi_cnt < c_HI_MIN);
  // Wrap is only flagged when the step delta is actually applied.
  assign w_ovf        = w_accept & ~w_wr_pos &
                        (w_filt[1] ? (r_pos == c_POS_MAX) : (r_pos == c_POS_MIN));

  assign w_set     = {w_rise & w_filt[2], w_ovf, w_short, w_setup_viol};
  assign w_clr     = w_wr_status ? avs_writedata[5:2] : 4'b0000;
  assign w_pos_ext = 32'($signed(r_pos));
  assign w_unused  = &{1'b0, avs_writedata};

  // Edge history, dir-age and high-width counters for violation detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_d  <= 1'b0;
      r_dir_d   <= 1'b0;
      r_dir_age <= c_AGE_SAT;
      r_hi_cnt  <= '0;
    end else begin
      r_step_d <= w_filt[0];
      r_dir_d  <= w_filt[1];
      if (w_dir_chg) begin
        r_dir_age <= '0;
      end else if (r_dir_age != c_AGE_SAT) begin
        r_dir_age <= r_dir_age + c_AGE_W'(1);
      end
      if (!w_filt[0]) begin
        r_hi_cnt <= '0;
      end else if (r_hi_cnt != c_HI_MIN) begin
        r_hi_cnt <= r_hi_cnt + c_HI_W'(1);
      end
    end
  end

  // Period counter idles at zero until the first rise, so PERIOD stays 0 until the second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_per_cnt <= '0;
      r_period  <= '0;
    end else if (w_rise) begin
      r_period  <= r_per_cnt;
      r_per_cnt <= 32'd1;
    end else if ((r_per_cnt != 32'd0) && (r_per_cnt != 32'hFFFF_FFFF)) begin
      r_per_cnt <= r_per_cnt + 32'd1;
    end
  end

  // Position, step total, sticky flags and step pulse; register writes take priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos      <= '0;
      r_total    <= '0;
      r_sticky   <= '0;
      step_pulse <= 1'b0;
    end else begin
      if (w_wr_pos) begin
        r_pos <= avs_writedata[POS_WIDTH-1:0];
      end else if (w_accept) begin
        r_pos <= w_filt[1] ? (r_pos + POS_WIDTH'(1)) : (r_pos - POS_WIDTH'(1));
      end
      if (w_wr_total) begin
        r_total <= '0;
      end else if (w_accept) begin
        r_total <= r_total + 32'd1;
      end
      r_sticky   <= (r_sticky & ~w_clr) | w_set;
      step_pulse <= w_accept;
    end
  end

  // Read data select.
  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      2'd0:    w_rd_mux = w_pos_ext;
      2'd1:    w_rd_mux = {26'd0, r_sticky, ~w_filt[2], w_filt[1]};
      2'd2:    w_rd_mux = r_period;
      default: w_rd_mux = r_total;
    endcase
  end

  // Registered read data with one cycle latency, held between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= w_rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_step_dir_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_step_dir_decoder                                          |
// | Description : Self-checking bench for step_dir_decoder.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_step_dir_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        step_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_k;
  int pulse_n;
  logic [31:0] rd;

  always #5 clk = ~clk;

  step_dir_decoder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .step         (step),
    .dir          (dir),
    .enable       (enable),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .step_pulse   (step_pulse)
  );

  typedef struct {
    logic        dir;
    logic        en;
    logic        do_load;
    logic [31:0] load;
    int          nsteps;
    int          hi;
    int          lo;
    logic        exp_pulse;
    logic [31:0] exp_pos;
    logic [31:0] exp_total;
    logic [31:0] exp_status;
    logic        chk_period;
    logic [31:0] exp_period;
  } row_t;

  row_t rows[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic avs_wr(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    avs_write = 1'b1; avs_address = addr; avs_writedata = data;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [1:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    avs_read = 1'b1; avs_address = addr;
    @(posedge clk); #1;
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  // One step of hi+lo cycles; records the cycle index of the first pulse and pulse count.
  task automatic do_step(input int hi, input int lo);
    pulse_k = -1;
    pulse_n = 0;
    @(posedge clk); #1;
    step = 1'b1;
    for (int k = 1; k < hi + lo; k++) begin
      @(posedge clk); #1;
      if (k == hi) step = 1'b0;
      @(negedge clk);
      if (step_pulse) begin
        pulse_n++;
        if (pulse_k < 0) pulse_k = k;
      end
    end
  endtask

  task automatic run_row(input int i);
    logic [31:0] exp_p;
    @(posedge clk); #1;
    dir = rows[i].dir;
    enable = rows[i].en;
    if (rows[i].do_load) avs_wr(2'd0, rows[i].load);
    repeat (30) @(posedge clk);
    exp_p = rows[i].exp_pulse ? {16'd1, 16'd8} : {16'd0, 16'hFFFF};
    for (int s = 0; s < rows[i].nsteps; s++) begin
      do_step(rows[i].hi, rows[i].lo);
      check($sformatf("row%0d step%0d pulse{n,k}", i, s), {pulse_n[15:0], pulse_k[15:0]}, exp_p);
    end
    avs_rd(2'd0, rd); check($sformatf("row%0d POSITION", i), rd, rows[i].exp_pos);
    avs_rd(2'd3, rd); check($sformatf("row%0d TOTAL", i), rd, rows[i].exp_total);
    avs_rd(2'd1, rd); check($sformatf("row%0d STATUS", i), rd, rows[i].exp_status);
    if (rows[i].chk_period) begin
      avs_rd(2'd2, rd); check($sformatf("row%0d PERIOD", i), rd, rows[i].exp_period);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            dir   en    load  value          n  hi   lo  pulse pos            total  status  chkP  period
    rows[0] = '{1'b1, 1'b0, 1'b0, 32'h0,          5, 100, 100, 1'b1, 32'd5,         32'd5,  32'h03, 1'b1, 32'd200};
    rows[1] = '{1'b1, 1'b0, 1'b0, 32'h0,          3,   3,  20, 1'b0, 32'd5,         32'd5,  32'h03, 1'b1, 32'd200};
    rows[2] = '{1'b0, 1'b0, 1'b1, 32'h0,          3, 100, 100, 1'b1, 32'hFFFFFFFD,  32'd8,  32'h02, 1'b1, 32'd200};
    rows[3] = '{1'b1, 1'b1, 1'b0, 32'h0,          4, 100, 100, 1'b0, 32'hFFFFFFFF,  32'd10, 32'h21, 1'b1, 32'd200};
    rows[4] = '{1'b1, 1'b0, 1'b1, 32'h7FFFFFFF,   1, 100, 100, 1'b1, 32'h80000000,  32'd11, 32'h33, 1'b0, 32'd0};
    rows[5] = '{1'b0, 1'b0, 1'b0, 32'h0,          1, 100, 100, 1'b1, 32'h7FFFFFFF,  32'd12, 32'h32, 1'b0, 32'd0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset readdata", avs_readdata, 32'd0);
    check("reset step_pulse", {31'd0, step_pulse}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    avs_rd(2'd0, rd); check("reset POSITION", rd, 32'd0);
    avs_rd(2'd1, rd); check("reset STATUS", rd, 32'd0);
    avs_rd(2'd2, rd); check("reset PERIOD", rd, 32'd0);
    avs_rd(2'd3, rd); check("reset TOTAL", rd, 32'd0);

    // Basic count, glitch rejection, down count
    for (int i = 0; i < 3; i++) run_row(i);

    // Dir change 5 cycles before step rise: SETUP, step still counted
    @(posedge clk); #1;
    dir = 1'b1;
    repeat (4) @(posedge clk);
    do_step(100, 100);
    avs_rd(2'd0, rd); check("setup POSITION", rd, 32'hFFFFFFFE);
    avs_rd(2'd3, rd); check("setup TOTAL", rd, 32'd9);
    avs_rd(2'd1, rd); check("setup STATUS", rd, 32'h07);

    // Short high pulse
    do_step(20, 100);
    avs_rd(2'd0, rd); check("short POSITION", rd, 32'hFFFFFFFF);
    avs_rd(2'd1, rd); check("short STATUS", rd, 32'h0F);

    // Clear SETUP and SHORT
    avs_wr(2'd1, 32'h3C);
    avs_rd(2'd1, rd); check("clear STATUS", rd, 32'h03);

    // Disabled steps, wrap up, wrap down
    for (int i = 3; i < 6; i++) run_row(i);

    // POSITION write colliding with an accepted step
    @(posedge clk); #1;
    step = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    avs_write = 1'b1; avs_address = 2'd0; avs_writedata = 32'd100;
    @(posedge clk); #1;
    avs_write = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    step = 1'b0;
    repeat (100) @(posedge clk);
    avs_rd(2'd0, rd); check("collide POSITION", rd, 32'd100);
    avs_rd(2'd3, rd); check("collide TOTAL", rd, 32'd13);

    // Reset asserted mid-pulse
    @(posedge clk); #1;
    step = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    step = 1'b0;
    enable = 1'b1;
    dir = 1'b0;
    @(negedge clk);
    check("midreset readdata", avs_readdata, 32'd0);
    check("midreset step_pulse", {31'd0, step_pulse}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    avs_rd(2'd0, rd); check("post-reset POSITION", rd, 32'd0);
    avs_rd(2'd1, rd); check("post-reset STATUS", rd, 32'd0);
    avs_rd(2'd2, rd); check("post-reset PERIOD", rd, 32'd0);
    avs_rd(2'd3, rd); check("post-reset TOTAL", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_dir_decoder.md
# step_dir_decoder

Receiving end of the EasyDriver step/dir/enable interface. It samples a step, dir and enable triplet, either looped back from an `easy_driver_*` conduit or taken from an external controller. It filters and synchronizes the three inputs, reconstructs signed motor position, measures step period and flags protocol violations. Results are exposed to the HPS through a small Avalon-MM slave, so software can cross-check commanded against emitted steps on the X/Y stage.

## Interface
Parameters:
- `POS_WIDTH`, 32: position register width (signed, two's complement), 2..32.
- `FILTER_CYCLES`, 4: consecutive stable samples required before a filtered input changes, ≥1.
- `MIN_HIGH_CYCLES`, 50: minimum filtered step high width (1 µs at 50 MHz).
- `DIR_SETUP_CYCLES`, 10: minimum cycles between a filtered dir change and the next filtered step rise.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `step`, in, 1: raw step input, asynchronous to `clk`.
- `dir`, in, 1: raw direction input; 1 = count up, 0 = count down.
- `enable`, in, 1: raw EasyDriver ENABLE, active-low (0 = driver enabled).
- `avs_address`, in, 2: register select.
- `avs_read`, in, 1: read strobe.
- `avs_write`, in, 1: write strobe.
- `avs_writedata`, in, 32: write data.
- `avs_readdata`, out, 32: read data, registered.
- `step_pulse`, out, 1: one-cycle pulse for each accepted step.

## Operation
- **Input path.** Each input passes through a 2-FF synchronizer, then a per-input filter.
  - Each filter has a counter that increments while the synchronized value differs from the filtered value. The counter clears when the two agree.
  - The filtered value takes the synchronized value once the counter reaches `FILTER_CYCLES`.
  - Any excursion shorter than `FILTER_CYCLES` cycles is discarded.
- **Accepted step.** An accepted step is a rising edge of filtered step while filtered enable = 0. On an accepted step:
  - position += 1 if filtered dir = 1, else position −= 1.
  - total_steps += 1 (unsigned 32 bit, wraps silently).
  - `step_pulse` = 1 for one cycle.
- **Position wrap.** Position wraps modulo 2^POS_WIDTH.
  - Max positive + 1 → max negative sets sticky OVF.
  - Max negative − 1 → max positive also sets OVF.
- **Disabled step.** A filtered step rise while filtered enable = 1 is not counted. It sets sticky DIS.
- **Dir setup.** A dir-age counter clears on every filtered dir change and saturates at `DIR_SETUP_CYCLES`.
  - A filtered step rise with dir-age < `DIR_SETUP_CYCLES` sets sticky SETUP.
  - The step is still counted, using the current filtered dir.
- **Pulse width.** A high-width counter runs while filtered step = 1.
  - At the falling edge, width < `MIN_HIGH_CYCLES` sets sticky SHORT.
- **Period.** A period counter counts cycles since the last filtered step rise and saturates at 2^32−1.
  - On each rise (enabled or not) its value is latched into PERIOD, then the counter restarts at 1.
  - PERIOD reads 0 until the second rise.
- **Register map** (word address):
  - 0 POSITION: R = sign-extended position. W = load position from `avs_writedata[POS_WIDTH-1:0]`.
  - 1 STATUS: R bit0 = filtered dir, bit1 = ~filtered enable, bit2 SETUP, bit3 SHORT, bit4 OVF, bit5 DIS, others 0. W: 1 clears the corresponding bit in [5:2]; bits [1:0] ignored.
  - 2 PERIOD: R only; writes ignored.
  - 3 TOTAL_STEPS: R; any W clears it to 0.
- **Simultaneous events:**
  - A POSITION write in the same cycle as an accepted step: the write wins and the step's position delta is dropped. total_steps still increments.
  - A STATUS clear in the same cycle as a new set of the same bit: set wins.
  - A TOTAL_STEPS write with an accepted step: the clear wins.

## Timing
- **Reset values:**
  - Asserting `reset_n` = 0 asynchronously clears all state: synchronizers, filters (filtered step/dir = 0, filtered enable = 1), counters, position, sticky bits, PERIOD and TOTAL_STEPS.
  - Exception: dir-age resets to `DIR_SETUP_CYCLES`, so the first step raises no false SETUP.
  - Outputs at reset: `avs_readdata` = 0, `step_pulse` = 0.
- **Step latency.** Let raw step first be sampled high at edge N.
  - Filtered step rises at edge N+2+`FILTER_CYCLES`.
  - Position, total_steps and `step_pulse` update at edge N+3+`FILTER_CYCLES`, which is N+7 at defaults.
  - dir and enable have identical latency. Setup is therefore judged on equal-delay filtered signals.
- **Avalon-MM:**
  - Fixed read latency of 1: `avs_readdata` is valid the cycle after `avs_read`.
  - `avs_readdata` holds its value until the next read.
  - Writes take effect at the edge where `avs_write` = 1. No wait states.
  - A read in the cycle after a write returns the written value.
- **Mid-operation reset.** Reset between a raw edge and filter acceptance loses that step. There is no partial state after release.

## Test plan
- **Basic count.** Defaults; enable = 0, dir = 1; 5 steps of 100 cycles high / 100 low → POSITION = 5, TOTAL_STEPS = 5, PERIOD = 200. Each `step_pulse` fires exactly 7 cycles after its raw rise.
- **Glitch rejection.** 3-cycle step glitches → no count. Then dir = 0 with 3 valid steps → POSITION = −3 (0xFFFFFFFD).
- **Violation flags:**
  - Dir toggled 5 cycles before a step rise → SETUP = 1, step counted.
  - 20-cycle high pulse → SHORT = 1.
  - Writing STATUS 0x3C clears SETUP and SHORT.
- **Disabled steps.** enable = 1, 4 steps → POSITION unchanged, DIS = 1, PERIOD still updated.
- **Wrap.** Write POSITION = 0x7FFFFFFF, one up-step → 0x80000000, OVF = 1. One down-step → 0x7FFFFFFF.
- **Collision and reset.** POSITION write of 100 coinciding with an accepted step → POSITION = 100, TOTAL_STEPS still increments. Then assert `reset_n` mid-pulse → all registers read 0 after release.
